hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage MIPS32 core. Watches ID/EX, IF/ID and EX/MEM state and drives
//  PC/IF/ID write enables, ID/EX bubble insertion, branch flushes and global hold for memory waits.

---
 rtl/hazard_ctrl.sv | 167 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS32 core: load-use stalls, branch flushes, memory-wait
// holds, halt drain and saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned MEM_TIMEOUT  = 64,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_id_ex_mem_read,
  input  logic [4:0]       i_id_ex_rt,
  input  logic [4:0]       i_if_id_rs,
  input  logic [4:0]       i_if_id_rt,
  input  logic             i_if_id_uses_rt,
  input  logic             i_branch_taken,
  input  logic             i_halt_req,
  input  logic             i_mem_busy,
  output logic             o_pc_write,
  output logic             o_if_id_write,
  output logic             o_if_id_flush,
  output logic             o_id_ex_bubble,
  output logic             o_ex_mem_flush,
  output logic             o_pipe_hold,
  output logic             o_halted,
  output logic             o_mem_timeout,
  output logic [CNT_W-1:0] o_stall_count,
  output logic [CNT_W-1:0] o_flush_count
);

  localparam int unsigned WaitW  = $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned DrainW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {StRun, StLoadStall, StMemWait, StDrain, StHalted} state_e;

  state_e             r_state, w_state_nxt;
  logic [WaitW-1:0]   r_wait_cnt, w_wait_nxt;
  logic [DrainW-1:0]  r_drain_cnt, w_drain_nxt;
  logic               r_mem_timeout;
  logic [CNT_W-1:0]   r_stall_cnt, r_flush_cnt;
  logic               w_load_use, w_flush_inc, w_timeout_hit;

  assign w_load_use = i_id_ex_mem_read && (i_id_ex_rt != 5'd0) &&
                      ((i_id_ex_rt == i_if_id_rs) ||
                       (i_if_id_uses_rt && (i_id_ex_rt == i_if_id_rt)));

  always_comb begin
    o_pc_write     = 1'b1;
    o_if_id_write  = 1'b1;
    o_if_id_flush  = 1'b0;
    o_id_ex_bubble = 1'b0;
    o_ex_mem_flush = 1'b0;
    o_pipe_hold    = 1'b0;
    o_halted       = 1'b0;
    w_state_nxt    = r_state;
    w_wait_nxt     = r_wait_cnt;
    w_drain_nxt    = r_drain_cnt;
    w_flush_inc    = 1'b0;
    w_timeout_hit  = 1'b0;

    unique case (r_state)
      StRun, StLoadStall, StMemWait: begin
        if (i_mem_busy) begin
          o_pipe_hold   = 1'b1;
          o_pc_write    = 1'b0;
          o_if_id_write = 1'b0;
          w_state_nxt   = StMemWait;
          if (r_state != StMemWait) begin
            w_wait_nxt = WaitW'(1);
          end else if (r_wait_cnt != '1) begin
            w_wait_nxt = r_wait_cnt + WaitW'(1);
          end
          w_timeout_hit = (w_wait_nxt == WaitW'(MEM_TIMEOUT));
        end else begin
          w_wait_nxt  = '0;
          w_state_nxt = StRun;
          if (i_branch_taken) begin
            o_if_id_flush  = 1'b1;
            o_id_ex_bubble = 1'b1;
            o_ex_mem_flush = 1'b1;
            w_flush_inc    = 1'b1;
          end else if (i_halt_req) begin
            o_pc_write     = 1'b0;
            o_if_id_write  = 1'b0;
            o_id_ex_bubble = 1'b1;
            w_state_nxt    = StDrain;
            w_drain_nxt    = DrainW'(1);
          end else if (w_load_use && (r_state != StLoadStall)) begin
            // Masked in LOAD_STALL so a load-use pair costs exactly one bubble.
            o_pc_write     = 1'b0;
            o_if_id_write  = 1'b0;
            o_id_ex_bubble = 1'b1;
            w_state_nxt    = StLoadStall;
          end
        end
      end
      StDrain: begin
        o_pc_write     = 1'b0;
        o_if_id_write  = 1'b0;
        o_id_ex_bubble = 1'b1;
        if (i_mem_busy) begin
          o_pipe_hold = 1'b1;
        end else if (i_branch_taken) begin
          // Older branch taken: the halt was fetched on the wrong path.
          o_pc_write     = 1'b1;
          o_if_id_write  = 1'b1;
          o_if_id_flush  = 1'b1;
          o_ex_mem_flush = 1'b1;
          w_flush_inc    = 1'b1;
          w_state_nxt    = StRun;
          w_drain_nxt    = '0;
        end else if (r_drain_cnt == DrainW'(DRAIN_CYCLES)) begin
          w_state_nxt = StHalted;
        end else begin
          w_drain_nxt = r_drain_cnt + DrainW'(1);
        end
      end
      StHalted: begin
        o_pc_write     = 1'b0;
        o_if_id_write  = 1'b0;
        o_id_ex_bubble = 1'b1;
        o_halted       = 1'b1;
      end
      default: begin
        w_state_nxt = StRun;
      end
    endcase

    if (!i_rst_n) begin
      o_pc_write     = 1'b0;
      o_if_id_write  = 1'b0;
      o_id_ex_bubble = 1'b1;
      o_if_id_flush  = 1'b0;
      o_ex_mem_flush = 1'b0;
      o_pipe_hold    = 1'b0;
      o_halted       = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= StRun;
      r_wait_cnt    <= '0;
      r_drain_cnt   <= '0;
      r_mem_timeout <= 1'b0;
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_wait_cnt  <= w_wait_nxt;
      r_drain_cnt <= w_drain_nxt;
      if (w_timeout_hit) begin
        r_mem_timeout <= 1'b1;
      end
      if (!o_pc_write && (r_state != StHalted) && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_flush_inc && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign o_mem_timeout = r_mem_timeout;
  assign o_stall_count = r_stall_cnt;
  assign o_flush_count = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: each vector pushes its expected outputs when driven; they are
// popped and compared once the combinational outputs have settled.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0, uses_rt = 1'b0, branch = 1'b0, halt = 1'b0, busy = 1'b0;
  logic [4:0]  id_ex_rt = '0, if_id_rs = '0, if_id_rt = '0;
  logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush;
  logic        pipe_hold, halted, mem_timeout;
  logic [15:0] stall_count, flush_count;

  typedef struct {
    logic [7:0] o;
    int         s;
    int         f;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .DRAIN_CYCLES(3),
    .MEM_TIMEOUT (4),
    .CNT_W       (16)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_id_ex_mem_read(mem_read),
    .i_id_ex_rt      (id_ex_rt),
    .i_if_id_rs      (if_id_rs),
    .i_if_id_rt      (if_id_rt),
    .i_if_id_uses_rt (uses_rt),
    .i_branch_taken  (branch),
    .i_halt_req      (halt),
    .i_mem_busy      (busy),
    .o_pc_write      (pc_write),
    .o_if_id_write   (if_id_write),
    .o_if_id_flush   (if_id_flush),
    .o_id_ex_bubble  (id_ex_bubble),
    .o_ex_mem_flush  (ex_mem_flush),
    .o_pipe_hold     (pipe_hold),
    .o_halted        (halted),
    .o_mem_timeout   (mem_timeout),
    .o_stall_count   (stall_count),
    .o_flush_count   (flush_count)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // ctl = {rst_n, mem_read, uses_rt, branch, halt, busy}
  // eo  = {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush, pipe_hold, halted, tmo}
  task automatic vec(input string tag, input logic [5:0] ctl, input logic [4:0] ert,
                     input logic [4:0] rs, input logic [4:0] rt, input logic [7:0] eo,
                     input int es, input int ef);
    exp_t e;
    @(negedge clk);
    {rst_n, mem_read, uses_rt, branch, halt, busy} = ctl;
    id_ex_rt = ert;
    if_id_rs = rs;
    if_id_rt = rt;
    exp_q.push_back('{o: eo, s: es, f: ef});
    #1;
    e = exp_q.pop_front();
    check_val({tag, "_out"}, {24'd0, pc_write, if_id_write, if_id_flush, id_ex_bubble,
                             ex_mem_flush, pipe_hold, halted, mem_timeout}, {24'd0, e.o});
    check_val({tag, "_stall"}, {16'd0, stall_count}, e.s);
    check_val({tag, "_flush"}, {16'd0, flush_count}, e.f);
  endtask

  localparam logic [7:0] Run   = 8'b1100_0000;
  localparam logic [7:0] Stall = 8'b0001_0000;
  localparam logic [7:0] Flush = 8'b1111_1000;
  localparam logic [7:0] Hold  = 8'b0000_0100;
  localparam logic [7:0] Halt  = 8'b0001_0010;

  initial begin
    vec("rst",        6'b000000, 0, 0, 0, Stall, 0, 0);
    vec("idle0",      6'b100000, 0, 0, 0, Run,   0, 0);
    // load-use on rs, then on rt, and the non-hazard variants
    vec("lu_rs",      6'b110000, 8, 8, 0, Stall, 0, 0);
    vec("lu_mask",    6'b110000, 8, 8, 0, Run,   1, 0);
    vec("lu_after",   6'b100000, 0, 0, 0, Run,   1, 0);
    vec("lu_rt",      6'b111000, 9, 3, 9, Stall, 1, 0);
    vec("lu_rt_done", 6'b100000, 0, 0, 0, Run,   2, 0);
    vec("no_uses_rt", 6'b110000, 9, 3, 9, Run,   2, 0);
    vec("no_read",    6'b101000, 8, 8, 8, Run,   2, 0);
    vec("zero_a",     6'b110000, 0, 0, 0, Run,   2, 0);
    vec("zero_b",     6'b110000, 0, 0, 0, Run,   2, 0);
    // branch beats load-use and does not enter LOAD_STALL
    vec("br_lu",      6'b110100, 8, 8, 0, Flush, 2, 0);
    vec("br_no_ls",   6'b110000, 8, 8, 0, Stall, 2, 1);
    vec("br_ls",      6'b110000, 8, 8, 0, Run,   3, 1);
    // memory wait with timeout at 4
    vec("busy1",      6'b100001, 0, 0, 0, Hold,  3, 1);
    vec("busy2",      6'b100001, 0, 0, 0, Hold,  4, 1);
    vec("busy3",      6'b100001, 0, 0, 0, Hold,  5, 1);
    vec("busy4",      6'b100001, 0, 0, 0, Hold,  6, 1);
    vec("busy5",      6'b100001, 0, 0, 0, Hold | 8'b1, 7, 1);
    vec("busy_end",   6'b100000, 0, 0, 0, Run  | 8'b1, 8, 1);
    vec("tmo_sticky", 6'b100000, 0, 0, 0, Run  | 8'b1, 8, 1);
    // halt drain to HALTED
    vec("rst2",       6'b000000, 0, 0, 0, Stall, 0, 0);
    vec("rel2",       6'b100000, 0, 0, 0, Run,   0, 0);
    vec("halt",       6'b100010, 0, 0, 0, Stall, 0, 0);
    vec("drain1",     6'b100000, 0, 0, 0, Stall, 1, 0);
    vec("drain2",     6'b100000, 0, 0, 0, Stall, 2, 0);
    vec("drain3",     6'b100000, 0, 0, 0, Stall, 3, 0);
    vec("halted_a",   6'b111111, 8, 8, 8, Halt,  4, 0);
    vec("halted_b",   6'b100000, 0, 0, 0, Halt,  4, 0);
    vec("rst_halt",   6'b000000, 0, 0, 0, Stall, 0, 0);
    vec("rel_halt",   6'b100000, 0, 0, 0, Run,   0, 0);
    // drain aborted by a branch in the 2nd drain cycle
    vec("halt_b",     6'b100010, 0, 0, 0, Stall, 0, 0);
    vec("drain_b1",   6'b100000, 0, 0, 0, Stall, 1, 0);
    vec("drain_br",   6'b100100, 0, 0, 0, Flush, 2, 0);
    vec("abort_a",    6'b100000, 0, 0, 0, Run,   2, 1);
    vec("abort_b",    6'b100000, 0, 0, 0, Run,   2, 1);
    // mem_busy freezes the drain count
    vec("halt_m",     6'b100010, 0, 0, 0, Stall, 2, 1);
    vec("drain_m1",   6'b100000, 0, 0, 0, Stall, 3, 1);
    vec("drain_busy", 6'b100001, 0, 0, 0, Stall | Hold, 4, 1);
    vec("drain_m2",   6'b100000, 0, 0, 0, Stall, 5, 1);
    vec("drain_m3",   6'b100000, 0, 0, 0, Stall, 6, 1);
    vec("halted_m",   6'b100000, 0, 0, 0, Halt,  7, 1);
    // reset while in LOAD_STALL
    vec("rst3",       6'b000000, 0, 0, 0, Stall, 0, 0);
    vec("rel3",       6'b100000, 0, 0, 0, Run,   0, 0);
    vec("lu_pre",     6'b110000, 8, 8, 0, Stall, 0, 0);
    vec("rst_ls",     6'b010000, 8, 8, 0, Stall, 0, 0);
    vec("rel_ls",     6'b100000, 0, 0, 0, Run,   0, 0);
    vec("lu_post",    6'b110000, 8, 8, 0, Stall, 0, 0);
    vec("lu_post2",   6'b110000, 8, 8, 0, Run,   1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
